// File: rtl/gmii_tx_sched.sv
// Two-source GMII transmit scheduler: PTP event frames win over general traffic
// (with a bounded PTP burst), framed with preamble/SFD/IFG and an SFD strobe for the TSU.
module gmii_tx_sched #(
    parameter int PRE_LEN   = 7,
    parameter int IFG_LEN   = 12,
    parameter int PTP_BURST = 4
) (
    input  logic       gmii_txclk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       ptp_req,
    input  logic [7:0] ptp_data,
    input  logic       ptp_last,
    input  logic       gen_req,
    input  logic [7:0] gen_data,
    input  logic       gen_last,
    output logic       ptp_rd,
    output logic       gen_rd,
    output logic       gmii_txctrl,
    output logic [7:0] gmii_txdata,
    output logic       gmii_txerr,
    output logic       sfd_pulse,
    output logic       sfd_src,
    output logic       frame_done,
    output logic       underrun
);

    // state | meaning
    // IDLE  | no frame, gap satisfied, waiting for a request
    // PRE   | 0x55 preamble bytes on the wire
    // SFD   | 0xD5 on the wire; first payload byte is popped here
    // DATA  | payload on the wire; next byte popped (last byte sends us to IFG)
    // IFG   | txctrl low, counting the inter-frame gap
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_IFG  = 3'd4;

    localparam int PRE_W   = $clog2(PRE_LEN + 1);
    localparam int IFG_W   = $clog2(IFG_LEN + 1);
    localparam int BURST_W = $clog2(PTP_BURST + 1);

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(PRE_LEN);
    localparam logic [IFG_W-1:0]   IFG_MAX   = IFG_W'(IFG_LEN);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(PTP_BURST);

    logic [2:0]         state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [IFG_W-1:0]   ifg_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               grant_ptp;

    logic               ifg_done;
    logic               arb_go;
    logic               pick_ptp;
    logic [BURST_W-1:0] burst_nxt;
    logic               pop_phase;
    logic               cur_req;
    logic [7:0]         cur_data;
    logic               cur_last;

    // The IFG->IDLE edge may also grant, so back-to-back frames see exactly IFG_LEN idle cycles.
    assign ifg_done  = (state == S_IFG) && (ifg_cnt == IFG_MAX);
    assign arb_go    = ((state == S_IDLE) || ifg_done) && tx_enable && (ptp_req || gen_req);
    assign pick_ptp  = ptp_req && !(gen_req && (burst_cnt == BURST_MAX));
    assign burst_nxt = (pick_ptp && gen_req)
                       ? ((burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1)
                       : '0;

    assign pop_phase = (state == S_SFD) || (state == S_DATA);
    assign cur_req   = grant_ptp ? ptp_req  : gen_req;
    assign cur_data  = grant_ptp ? ptp_data : gen_data;
    assign cur_last  = grant_ptp ? ptp_last : gen_last;

    assign ptp_rd = pop_phase && grant_ptp  && ptp_req;
    assign gen_rd = pop_phase && !grant_ptp && gen_req;

    always_ff @(posedge gmii_txclk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            ifg_cnt     <= '0;
            burst_cnt   <= '0;
            grant_ptp   <= 1'b0;
            gmii_txctrl <= 1'b0;
            gmii_txdata <= 8'h00;
            gmii_txerr  <= 1'b0;
            sfd_pulse   <= 1'b0;
            sfd_src     <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            gmii_txerr <= 1'b0;
            sfd_pulse  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (arb_go) begin
                state       <= S_PRE;
                pre_cnt     <= PRE_W'(1);
                grant_ptp   <= pick_ptp;
                burst_cnt   <= burst_nxt;
                gmii_txctrl <= 1'b1;
                gmii_txdata <= 8'h55;
                sfd_src     <= 1'b0;
            end else begin
                case (state)
                    S_PRE: begin
                        gmii_txctrl <= 1'b1;
                        if (pre_cnt == PRE_MAX) begin
                            state       <= S_SFD;
                            gmii_txdata <= 8'hD5;
                            sfd_pulse   <= 1'b1;
                            sfd_src     <= grant_ptp;
                        end else begin
                            pre_cnt     <= pre_cnt + 1'b1;
                            gmii_txdata <= 8'h55;
                        end
                    end
                    S_SFD, S_DATA: begin
                        gmii_txctrl <= 1'b1;
                        ifg_cnt     <= '0;
                        if (cur_req) begin
                            gmii_txdata <= cur_data;
                            frame_done  <= cur_last;
                            state       <= cur_last ? S_IFG : S_DATA;
                        end else begin
                            // Source ran dry mid-frame: one errored cycle, no pop.
                            gmii_txdata <= 8'h00;
                            gmii_txerr  <= 1'b1;
                            underrun    <= 1'b1;
                            state       <= S_IFG;
                        end
                    end
                    S_IFG: begin
                        gmii_txctrl <= 1'b0;
                        gmii_txdata <= 8'h00;
                        sfd_src     <= 1'b0;
                        if (ifg_done) begin
                            state <= S_IDLE;
                        end else begin
                            ifg_cnt <= ifg_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state       <= S_IDLE;
                        gmii_txctrl <= 1'b0;
                        gmii_txdata <= 8'h00;
                        sfd_src     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Randomized scoreboard bench for gmii_tx_sched: frames are predicted from the
// arbitration rules at push time and checked per wire cycle by a negedge monitor.
`timescale 1ns/1ps
module tb_gmii_tx_sched;
    localparam int PRE_LEN   = 7;
    localparam int IFG_LEN   = 12;
    localparam int PTP_BURST = 4;

    logic       gmii_txclk = 1'b0;
    logic       rst        = 1'b1;
    logic       tx_enable  = 1'b0;
    logic       ptp_req    = 1'b0;
    logic [7:0] ptp_data   = 8'h00;
    logic       ptp_last   = 1'b0;
    logic       gen_req    = 1'b0;
    logic [7:0] gen_data   = 8'h00;
    logic       gen_last   = 1'b0;
    logic       ptp_rd;
    logic       gen_rd;
    logic       gmii_txctrl;
    logic [7:0] gmii_txdata;
    logic       gmii_txerr;
    logic       sfd_pulse;
    logic       sfd_src;
    logic       frame_done;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    gmii_tx_sched #(.PRE_LEN(PRE_LEN), .IFG_LEN(IFG_LEN), .PTP_BURST(PTP_BURST)) dut (
        .gmii_txclk (gmii_txclk),
        .rst        (rst),
        .tx_enable  (tx_enable),
        .ptp_req    (ptp_req),
        .ptp_data   (ptp_data),
        .ptp_last   (ptp_last),
        .gen_req    (gen_req),
        .gen_data   (gen_data),
        .gen_last   (gen_last),
        .ptp_rd     (ptp_rd),
        .gen_rd     (gen_rd),
        .gmii_txctrl(gmii_txctrl),
        .gmii_txdata(gmii_txdata),
        .gmii_txerr (gmii_txerr),
        .sfd_pulse  (sfd_pulse),
        .sfd_src    (sfd_src),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 gmii_txclk = ~gmii_txclk;

    typedef struct packed {
        logic       src;
        logic       abort;
        logic [7:0] len;
        logic [7:0] gap;
    } exp_t;

    logic [8:0] ptp_q[$];
    logic [8:0] gen_q[$];
    exp_t       pend_p[$];
    exp_t       pend_g[$];
    logic [7:0] pend_pb[$];
    logic [7:0] pend_gb[$];
    exp_t       sb_q[$];
    logic [7:0] sb_bytes[$];
    int         m_burst = 0;

    logic        in_frame  = 1'b0;
    logic        gap_valid = 1'b0;
    int          gap_cnt   = 0;
    int          gap_meas  = 0;
    int          prd       = 0;
    int          grd       = 0;
    int          idle_bad  = 0;
    int          frame_no  = 0;
    logic [12:0] cap[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Loads a frame into a source FIFO; tracked frames also go to the pending model lists.
    task automatic push_frame(input bit src, input int len, input int base, input bit abort,
                              input bit track);
        exp_t       e;
        logic [7:0] d;
        logic       l;
        for (int i = 0; i < len; i++) begin
            d = (base >= 0) ? 8'(base + i) : 8'($urandom);
            l = !abort && (i == len - 1);
            if (src) begin
                ptp_q.push_back({l, d});
                if (track) pend_pb.push_back(d);
            end else begin
                gen_q.push_back({l, d});
                if (track) pend_gb.push_back(d);
            end
        end
        e.src   = src;
        e.abort = abort;
        e.len   = 8'(len);
        e.gap   = 8'd0;
        if (track) begin
            if (src) pend_p.push_back(e);
            else     pend_g.push_back(e);
        end
    endtask

    // Reference arbitration: PTP first unless GEN waits and PTP has used its burst allowance.
    task automatic schedule(input int first_gap);
        exp_t e;
        bit   take_p;
        int   g = first_gap;
        while (pend_p.size() > 0 || pend_g.size() > 0) begin
            take_p = (pend_p.size() > 0) && !(pend_g.size() > 0 && m_burst == PTP_BURST);
            if (take_p) begin
                m_burst = (pend_g.size() > 0) ? ((m_burst < PTP_BURST) ? m_burst + 1 : m_burst) : 0;
                e = pend_p.pop_front();
                for (int j = 0; j < int'(e.len); j++) sb_bytes.push_back(pend_pb.pop_front());
            end else begin
                m_burst = 0;
                e = pend_g.pop_front();
                for (int j = 0; j < int'(e.len); j++) sb_bytes.push_back(pend_gb.pop_front());
            end
            e.gap = 8'(g);
            sb_q.push_back(e);
            g = IFG_LEN;
        end
    endtask

    // Show-ahead source FIFOs: rd seen before the edge pops the head just after it.
    initial begin
        logic       sp;
        logic       sg;
        logic [8:0] h;
        forever begin
            @(negedge gmii_txclk);
            sp = ptp_rd;
            sg = gen_rd;
            @(posedge gmii_txclk);
            #1;
            if (sp && ptp_q.size() > 0) void'(ptp_q.pop_front());
            if (sg && gen_q.size() > 0) void'(gen_q.pop_front());
            ptp_req  = ptp_q.size() > 0;
            h        = ptp_req ? ptp_q[0] : 9'd0;
            ptp_last = h[8];
            ptp_data = h[7:0];
            gen_req  = gen_q.size() > 0;
            h        = gen_req ? gen_q[0] : 9'd0;
            gen_last = h[8];
            gen_data = h[7:0];
        end
    end

    task automatic finish_frame();
        exp_t        e;
        logic [7:0]  fb[$];
        logic [12:0] ex;
        int          L;
        if (sb_q.size() == 0) begin
            chk("unexpected_frame_len", cap.size(), 0);
            return;
        end
        e = sb_q.pop_front();
        for (int j = 0; j < int'(e.len); j++) fb.push_back(sb_bytes.pop_front());
        L = PRE_LEN + 1 + int'(e.len) + int'(e.abort);
        chk($sformatf("frame%0d_len", frame_no), cap.size(), L);
        if (e.gap != 8'd0)
            chk($sformatf("frame%0d_ifg_exact", frame_no), gap_meas, int'(e.gap));
        else if (gap_valid)
            chk($sformatf("frame%0d_ifg_min", frame_no), int'(gap_meas >= IFG_LEN), 1);
        for (int i = 0; i < cap.size() && i < L; i++) begin
            if (i < PRE_LEN)
                ex = {8'h55, 5'b00000};
            else if (i == PRE_LEN)
                ex = {8'hD5, 1'b0, 1'b1, e.src, 2'b00};
            else if (i < PRE_LEN + 1 + int'(e.len))
                ex = {fb[i - PRE_LEN - 1], 1'b0, 1'b0, e.src, (!e.abort && i == L - 1), 1'b0};
            else
                ex = {8'h00, 1'b1, 1'b0, e.src, 1'b0, 1'b1};
            chk($sformatf("frame%0d_cyc%0d{data,err,sfd,src,done,urun}", frame_no, i),
                int'(cap[i]), int'(ex));
        end
        chk($sformatf("frame%0d_rd_granted", frame_no), e.src ? prd : grd, int'(e.len));
        chk($sformatf("frame%0d_rd_other", frame_no), e.src ? grd : prd, 0);
        frame_no++;
    endtask

    // Monitor: captures each txctrl run and measures the low gap before it.
    initial begin
        forever begin
            @(negedge gmii_txclk);
            if (rst) begin
                in_frame  = 1'b0;
                gap_valid = 1'b0;
                gap_cnt   = 0;
                cap.delete();
            end else if (gmii_txctrl) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    gap_meas = gap_cnt;
                    prd      = 0;
                    grd      = 0;
                    cap.delete();
                end
                cap.push_back({gmii_txdata, gmii_txerr, sfd_pulse, sfd_src, frame_done, underrun});
                prd += int'(ptp_rd);
                grd += int'(gen_rd);
            end else begin
                if (ptp_rd || gen_rd || gmii_txerr || sfd_pulse || frame_done || underrun ||
                    gmii_txdata != 8'h00)
                    idle_bad++;
                if (in_frame) begin
                    finish_frame();
                    in_frame  = 1'b0;
                    gap_valid = 1'b1;
                    gap_cnt   = 1;
                end else begin
                    gap_cnt++;
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() > 0 || in_frame || ptp_q.size() > 0 || gen_q.size() > 0) && n < 5000) begin
            @(negedge gmii_txclk);
            n++;
        end
        chk(name, int'(n < 5000), 1);
        repeat (IFG_LEN + 2) @(negedge gmii_txclk);
    endtask

    task automatic wait_for(input int which, input string name);
        int   n   = 0;
        logic hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge gmii_txclk);
            n++;
            case (which)
                0:       hit = sfd_pulse;
                1:       hit = frame_done;
                default: hit = underrun;
            endcase
        end
        chk(name, int'(hit), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int np;
        int ng;

        repeat (3) @(negedge gmii_txclk);
        chk("rst_txctrl", int'(gmii_txctrl), 0);
        chk("rst_txdata", int'(gmii_txdata), 0);
        chk("rst_txerr", int'(gmii_txerr), 0);
        chk("rst_sfd_pulse", int'(sfd_pulse), 0);
        chk("rst_sfd_src", int'(sfd_src), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_rd", int'({ptp_rd, gen_rd}), 0);
        rst       = 1'b0;
        tx_enable = 1'b1;
        repeat (3) @(negedge gmii_txclk);
        chk("idle_no_req_txctrl", int'(gmii_txctrl), 0);

        push_frame(1'b1, 4, 8'hA1, 1'b0, 1'b1);
        schedule(0);
        wait_drain("single_frame_drain");

        push_frame(1'b1, 3, -1, 1'b0, 1'b1);
        push_frame(1'b1, 3, -1, 1'b0, 1'b1);
        schedule(0);
        wait_drain("back_to_back_drain");

        for (int i = 0; i < 9; i++) push_frame(1'b1, 2, -1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) push_frame(1'b0, 2, -1, 1'b0, 1'b1);
        schedule(0);
        wait_drain("starvation_drain");

        for (int r = 0; r < 4; r++) begin
            np = int'($urandom_range(1, 7));
            ng = int'($urandom_range(1, 4));
            for (int i = 0; i < np; i++) push_frame(1'b1, int'($urandom_range(1, 6)), -1, 1'b0, 1'b1);
            for (int i = 0; i < ng; i++) push_frame(1'b0, int'($urandom_range(1, 6)), -1, 1'b0, 1'b1);
            schedule(0);
            wait_drain($sformatf("random%0d_drain", r));
        end

        push_frame(1'b0, 2, -1, 1'b1, 1'b1);
        schedule(0);
        wait_for(2, "underrun_seen");
        push_frame(1'b1, 3, -1, 1'b0, 1'b1);
        schedule(IFG_LEN);
        wait_drain("underrun_drain");

        push_frame(1'b1, 5, -1, 1'b0, 1'b1);
        schedule(0);
        wait_for(0, "txen_sfd_seen");
        tx_enable = 1'b0;
        push_frame(1'b0, 3, -1, 1'b0, 1'b1);
        schedule(0);
        wait_for(1, "txen_frame_completes");
        cnt = 0;
        repeat (30) begin
            @(negedge gmii_txclk);
            cnt += int'(gmii_txctrl);
        end
        chk("txen_low_no_grant", cnt, 0);
        tx_enable = 1'b1;
        @(posedge gmii_txclk);
        #1;
        chk("txen_grant_latency", int'({gmii_txctrl, gmii_txdata}), int'({1'b1, 8'h55}));
        wait_drain("txen_drain");

        push_frame(1'b1, 10, -1, 1'b0, 1'b0);
        wait_for(0, "rst_frame_sfd_seen");
        repeat (3) @(posedge gmii_txclk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_txctrl", int'(gmii_txctrl), 0);
        chk("async_rst_txerr", int'(gmii_txerr), 0);
        chk("async_rst_sfd_pulse", int'(sfd_pulse), 0);
        chk("async_rst_txdata", int'(gmii_txdata), 0);
        chk("async_rst_sfd_src", int'(sfd_src), 0);
        ptp_q.delete();
        gen_q.delete();
        m_burst = 0;
        push_frame(1'b1, 2, -1, 1'b0, 1'b1);
        schedule(0);
        @(negedge gmii_txclk);
        @(negedge gmii_txclk);
        rst = 1'b0;
        @(posedge gmii_txclk);
        #1;
        chk("post_rst_latency", int'({gmii_txctrl, gmii_txdata}), int'({1'b1, 8'h55}));
        wait_drain("post_rst_drain");

        chk("idle_outputs_clean", idle_bad, 0);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gmii_tx_sched.md
# gmii_tx_sched

Two-source GMII transmit scheduler for the PTP datapath. Arbitrates between a high-priority PTP event-frame source and a low-priority general-traffic source, each a show-ahead byte FIFO. Frames the winner onto GMII TX with preamble, SFD and inter-frame gap, and emits an SFD strobe for the time-stamp unit. It sits between the frame buffers and the GMII TX pins, which the TSU taps.

## Interface
- PRE_LEN, 7: number of 0x55 preamble bytes before SFD (1..15).
- IFG_LEN, 12: minimum idle cycles (txctrl low) between frames (1..31).
- PTP_BURST, 4: consecutive PTP grants allowed while gen_req is pending (1..15).
- gmii_txclk  in  1  GMII transmit clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_enable  in  1  when low, no new grant; a frame in progress completes.
- ptp_req / gen_req  in  1  source has a frame byte available (show-ahead).
- ptp_data / gen_data  in  8  current head byte; valid while *_req high.
- ptp_last / gen_last  in  1  head byte is the frame's last byte.
- ptp_rd / gen_rd  out  1  pop strobe (combinational from state); byte is consumed at this edge.
- gmii_txctrl  out  1  GMII TX_EN.
- gmii_txdata  out  8  GMII TXD.
- gmii_txerr  out  1  GMII TX_ER.
- sfd_pulse  out  1  high for exactly the cycle the 0xD5 SFD is on gmii_txdata.
- sfd_src  out  1  granted source, valid with sfd_pulse and held to frame end (1 = PTP).
- frame_done  out  1  one-cycle pulse on the cycle the final frame byte is on the wire.
- underrun  out  1  one-cycle pulse when a frame is aborted for source underrun.

## Operation
- States: IDLE, PRE, SFD, DATA, IFG. Reset: IDLE, IFG satisfied, burst count 0.
- All GMII and status outputs are registered and reset to 0.
- IDLE:
  - Arbitration runs when tx_enable=1 and either req=1.
  - Winner: PTP if ptp_req, unless gen_req=1 and burst count = PTP_BURST, in which case GEN wins.
  - Burst count: +1 on each PTP grant while gen_req=1; cleared on a GEN grant or whenever gen_req=0 at arbitration. Saturates at PTP_BURST.
  - The grant edge drives the first 0x55 (txctrl=1); go to PRE.
- PRE: drive 0x55 until PRE_LEN bytes total, then go to SFD. The SFD edge drives 0xD5 and sets sfd_pulse=1.
- SFD and DATA: the granted *_rd = granted *_req whenever the current byte is not yet last. On that edge, txdata ← source head byte and txctrl=1.
  - A popped byte with *_last=1 also asserts frame_done on the same output cycle; the next edge goes to IFG with txctrl=0 and txdata=0x00.
- Underrun: the granted req is low while a pop is due. Then gmii_txctrl=1, gmii_txerr=1, txdata=0x00 for one cycle, underrun=1; then go to IFG. There is no pop, and the source is expected to flush its remnant.
- IFG: count idle cycles; after IFG_LEN go to IDLE. Arbitration in IDLE on the same edge is allowed, so back-to-back frames have exactly IFG_LEN low cycles.
- The non-granted source is never popped. Requests arriving mid-frame wait.
- tx_enable falling mid-frame has no effect until IDLE.
- Reset mid-frame: outputs go to 0 immediately and the state returns to IDLE. The source must flush itself.
- A frame whose first data byte is already last is a legal 1-byte payload.

## Timing
- req sampled high in IDLE at edge k → first preamble byte on gmii_txdata after edge k. Latency is 1 cycle.
- SFD after edge k+PRE_LEN. First payload byte after edge k+PRE_LEN+1. That payload byte was popped at the same edge (rd high during the SFD cycle).
- An N-byte payload gives a txctrl-high run of PRE_LEN+1+N cycles.
- Underrun adds one errored cycle instead of a payload byte.
- Minimum frame period: PRE_LEN+1+N+IFG_LEN cycles.

## Test plan
- Single frame: ptp_req with 4 bytes 0xA1..0xA4 (last on 0xA4), defaults → txctrl high 12 cycles: seven 0x55, 0xD5 with sfd_pulse and sfd_src=1, then A1..A4. frame_done is high with A4. ptp_rd is high 4 cycles.
- Back-to-back: two queued PTP 3-byte frames → exactly 12 low cycles between txctrl runs. The second preamble starts on the 13th cycle.
- Priority/starvation: both sources are continuously full of 2-byte frames → grant order P,P,P,P,G,P,P,P,P,G. gen_rd is never high during a PTP frame.
- Underrun: gen frame where gen_req drops after byte 2 → one cycle with txctrl=1, txerr=1, txdata=0x00; underrun pulse; no frame_done; then 12 idle cycles.
- tx_enable: deassert during a PTP frame → the frame completes; no new preamble while low. Reassert with gen_req=1 → preamble 1 cycle later (if IFG is satisfied).
- Reset mid-DATA: assert rst asynchronously → txctrl, txerr and sfd_pulse drop without waiting for a clock. After release with ptp_req=1, the next preamble starts 1 cycle after the first sampling edge.
